// File: rtl/thermo_frame_gen.sv
// Thermometer frame generator: turns a binary ones-count into SAMPLES beats of OSF
// thermometer-coded bits, with valid/ready handshakes on both sides.
module thermo_frame_gen #(
  parameter int unsigned SAMPLES = 2,
  parameter int unsigned OSF     = 8,
  localparam int unsigned CW     = $clog2(SAMPLES * OSF) + 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [CW-1:0] in_count,
  input  logic          in_valid,
  output logic          in_ready,
  output logic [OSF-1:0] out_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic          out_last,
  output logic          out_sat
);

  localparam int unsigned N  = SAMPLES * OSF;
  localparam int unsigned BW = (SAMPLES > 1) ? $clog2(SAMPLES) : 1;
  localparam logic [CW-1:0] NCount   = CW'(N);
  localparam logic [CW-1:0] OsfCount = CW'(OSF);
  localparam logic [BW-1:0] LastBeat = BW'(SAMPLES - 1);

  typedef enum logic [0:0] {StIdle, StEmit} state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] rem_q, rem_d;
  logic [BW-1:0] beat_q, beat_d;
  logic          sat_q, sat_d;
  // Holds in_ready low until the first clock edge after reset release.
  logic          active_q;

  logic          is_last;
  logic          accept;
  logic          xfer;
  logic [CW-1:0] step;
  logic [CW-1:0] load_rem;

  assign is_last  = (beat_q == LastBeat);
  assign accept   = in_valid & in_ready;
  assign xfer     = out_valid & out_ready;
  assign step     = (rem_q > OsfCount) ? OsfCount : rem_q;
  assign load_rem = (in_count > NCount) ? NCount : in_count;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= StIdle;
      rem_q    <= '0;
      beat_q   <= '0;
      sat_q    <= 1'b0;
      active_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      rem_q    <= rem_d;
      beat_q   <= beat_d;
      sat_q    <= sat_d;
      active_q <= 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    beat_d  = beat_q;
    sat_d   = sat_q;
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          state_d = StEmit;
          rem_d   = load_rem;
          sat_d   = (in_count > NCount);
          beat_d  = '0;
        end
      end
      StEmit: begin
        if (xfer) begin
          if (!is_last) begin
            rem_d  = rem_q - step;
            beat_d = beat_q + BW'(1);
          end else if (accept) begin
            // Back-to-back: next frame loads on the last-beat transfer.
            rem_d  = load_rem;
            sat_d  = (in_count > NCount);
            beat_d = '0;
          end else begin
            state_d = StIdle;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    out_last  = 1'b0;
    out_sat   = 1'b0;
    out_data  = '0;
    unique case (state_q)
      StIdle: in_ready = active_q;
      StEmit: begin
        out_valid = 1'b1;
        out_last  = is_last;
        out_sat   = sat_q;
        in_ready  = out_ready & is_last;
        for (int unsigned i = 0; i < OSF; i++) begin
          out_data[i] = (rem_q > CW'(i));
        end
      end
      default: ;
    endcase
  end

endmodule
